// File: rtl/apb_master_mux.sv
// APB4 master with address decode onto NUM_SLAVES one-hot selects, response muxing,
// slave-error reporting, wait-state timeout and decode-error completion.
module apb_master_mux #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int NUM_SLAVES    = 4,
    parameter int SLV_SPAN_LOG2 = 12,
    parameter int TIMEOUT       = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         CMD_VALID,
    output logic                         CMD_READY,
    input  logic                         CMD_WRITE,
    input  logic [ADDR_W-1:0]            CMD_ADDR,
    input  logic [DATA_W-1:0]            CMD_WDATA,
    input  logic [DATA_W/8-1:0]          CMD_STRB,
    output logic                         RSP_VALID,
    output logic [DATA_W-1:0]            RSP_RDATA,
    output logic                         RSP_ERR,
    output logic                         RSP_TIMEOUT,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    output logic [ADDR_W-1:0]            PADDR,
    output logic                         PWRITE,
    output logic [DATA_W-1:0]            PWDATA,
    output logic [DATA_W/8-1:0]          PSTRB,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W:0]   NS       = (IDX_W + 1)'(NUM_SLAVES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    decode_ok;
    logic [NUM_SLAVES-1:0]   psel_dec;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_W-1:0]       rdata_sel;

    assign idx       = CMD_ADDR[SLV_SPAN_LOG2 +: IDX_W];
    assign decode_ok = ({1'b0, idx} < NS);
    assign CMD_READY = (state == IDLE) && !PRESET;

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_dec
        assign psel_dec[g] = (idx == IDX_W'(g));
    end

    // PSEL is one-hot during ACCESS, so AND-OR muxing picks exactly the addressed slave.
    assign sel_ready = |(PREADY & PSEL);
    assign sel_err   = |(PSLVERR & PSEL);

    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            if (PSEL[i]) rdata_sel = rdata_sel | PRDATA[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            cnt         <= '0;
            PSEL        <= '0;
            PENABLE     <= 1'b0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            RSP_VALID   <= 1'b0;
            RSP_RDATA   <= '0;
            RSP_ERR     <= 1'b0;
            RSP_TIMEOUT <= 1'b0;
        end else begin
            RSP_VALID <= 1'b0;
            case (state)
                IDLE: if (CMD_VALID) begin
                    if (decode_ok) begin
                        state  <= SETUP;
                        PSEL   <= psel_dec;
                        PADDR  <= CMD_ADDR;
                        PWRITE <= CMD_WRITE;
                        PWDATA <= CMD_WDATA;
                        PSTRB  <= CMD_WRITE ? CMD_STRB : '0;
                    end else begin
                        // Unmapped window: complete immediately without touching the bus.
                        RSP_VALID   <= 1'b1;
                        RSP_ERR     <= 1'b1;
                        RSP_TIMEOUT <= 1'b0;
                        RSP_RDATA   <= '0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        state       <= IDLE;
                        PSEL        <= '0;
                        PENABLE     <= 1'b0;
                        RSP_VALID   <= 1'b1;
                        RSP_ERR     <= sel_err;
                        RSP_TIMEOUT <= 1'b0;
                        RSP_RDATA   <= (!PWRITE && !sel_err) ? rdata_sel : '0;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        state       <= IDLE;
                        PSEL        <= '0;
                        PENABLE     <= 1'b0;
                        RSP_VALID   <= 1'b1;
                        RSP_ERR     <= 1'b1;
                        RSP_TIMEOUT <= 1'b1;
                        RSP_RDATA   <= '0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_mux.sv
// Randomised scoreboard bench for apb_master_mux: 3 slaves (slave window 3 unmapped), TIMEOUT 16.
module tb_apb_master_mux;
    localparam int NS = 3;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          CMD_VALID, CMD_READY, CMD_WRITE;
    logic [31:0]   CMD_ADDR, CMD_WDATA;
    logic [3:0]    CMD_STRB;
    logic          RSP_VALID, RSP_ERR, RSP_TIMEOUT;
    logic [31:0]   RSP_RDATA;
    logic [NS-1:0] PSEL;
    logic          PENABLE, PWRITE;
    logic [31:0]   PADDR, PWDATA;
    logic [3:0]    PSTRB;
    logic [NS-1:0] PREADY, PSLVERR;
    logic [NS*32-1:0] PRDATA;

    apb_master_mux #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(NS), .SLV_SPAN_LOG2(12), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_STRB(CMD_STRB),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          w;     // wait states the addressed slave inserts
        logic        err;
        logic [31:0] rd;
    } cmd_t;

    typedef struct {
        logic        err;
        logic        to;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    cmd_t cur;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: outcome of one command from the protocol rules alone.
    function automatic exp_t predict(input cmd_t c, input int acc);
        exp_t e;
        int   idx;
        idx   = int'(c.addr[13:12]);
        e.acc = acc;
        e.to  = 1'b0;
        e.rdata = '0;
        if (idx >= NS) begin
            e.err = 1'b1; e.lat = 1;
        end else if (c.w >= TO) begin
            e.err = 1'b1; e.to = 1'b1; e.lat = 2 + TO;
        end else begin
            e.err = c.err; e.lat = 3 + c.w;
            if (!c.wr && !c.err) e.rdata = c.rd;
        end
        return e;
    endfunction

    // Slave responders plus monitor/scoreboard checker.
    always @(negedge PCLK) begin
        for (int i = 0; i < NS; i++) begin
            PREADY[i]  = 1'($urandom);
            PSLVERR[i] = 1'($urandom);
            PRDATA[i*32 +: 32] = $urandom;
        end
        if (PSEL != '0 && PENABLE) begin
            for (int i = 0; i < NS; i++) if (PSEL[i]) begin
                PREADY[i]  = (acc_cnt == cur.w);
                PSLVERR[i] = cur.err;
                PRDATA[i*32 +: 32] = cur.rd;
            end
            acc_cnt++;
        end else begin
            acc_cnt = 0;
        end

        if (PSEL != '0 && !PENABLE) begin
            logic [NS-1:0] ep;
            ep = '0;
            ep[cur.addr[13:12]] = 1'b1;
            chk("setup_psel", 64'(PSEL), 64'(ep));
            chk("setup_paddr", 64'(PADDR), 64'(cur.addr));
            chk("setup_pwrite", 64'(PWRITE), 64'(cur.wr));
            chk("setup_pstrb", 64'(PSTRB), cur.wr ? 64'(cur.strb) : 64'(0));
            if (cur.wr) chk("setup_pwdata", 64'(PWDATA), 64'(cur.wdata));
        end

        if (RSP_VALID) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_lat", 64'(cyc - e.acc), 64'(e.lat));
                chk("rsp_err", 64'(RSP_ERR), 64'(e.err));
                chk("rsp_timeout", 64'(RSP_TIMEOUT), 64'(e.to));
                chk("rsp_rdata", 64'(RSP_RDATA), 64'(e.rdata));
                chk("rsp_psel_idle", 64'({PSEL, PENABLE}), 64'(0));
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] s, input int w, input logic e, input logic [31:0] rd);
        cmd_t c;
        bit   ok;
        c.wr = wr; c.addr = a; c.wdata = wd; c.strb = s; c.w = w; c.err = e; c.rd = rd;
        CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = a; CMD_WDATA = wd; CMD_STRB = s;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (CMD_READY) begin ok = 1'b1; break; end
            @(negedge PCLK);
        end
        if (!ok) begin
            chk("cmd_ready_wait", 64'(0), 64'(1));
        end else begin
            cur = c;
            sb.push_back(predict(c, cyc));
        end
        @(negedge PCLK);
        CMD_VALID = 1'b0;
        CMD_WRITE = 1'($urandom); CMD_ADDR = $urandom; CMD_WDATA = $urandom; CMD_STRB = 4'($urandom);
    endtask

    initial begin
        PRESET = 1'b1; CMD_VALID = 1'b0; CMD_WRITE = 1'b0;
        CMD_ADDR = '0; CMD_WDATA = '0; CMD_STRB = '0;
        cur = '{wr: 1'b0, addr: 32'h0, wdata: 32'h0, strb: 4'h0, w: 0, err: 1'b0, rd: 32'h0};
        repeat (3) @(negedge PCLK);
        chk("rst_psel", 64'({PSEL, PENABLE}), 64'(0));
        chk("rst_rsp_valid", 64'(RSP_VALID), 64'(0));
        chk("rst_cmd_ready", 64'(CMD_READY), 64'(0));
        PRESET = 1'b0;
        #1;
        chk("rst_release_ready", 64'(CMD_READY), 64'(1));

        // Reset in the middle of a long ACCESS: transfer is dropped with no response.
        issue(1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 4'hF, 30, 1'b0, 32'h0);
        repeat (3) @(negedge PCLK);
        chk("midacc_penable", 64'(PENABLE), 64'(1));
        PRESET = 1'b1;
        sb.delete();
        @(negedge PCLK);
        chk("midrst_psel", 64'({PSEL, PENABLE}), 64'(0));
        chk("midrst_rsp_valid", 64'(RSP_VALID), 64'(0));
        chk("midrst_cmd_ready", 64'(CMD_READY), 64'(0));
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);

        // Directed cases.
        issue(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0);
        repeat (4) @(negedge PCLK);
        issue(1'b0, 32'h0000_2010, 32'h0, 4'hF, 3, 1'b0, 32'h1234_5678);
        repeat (8) @(negedge PCLK);
        issue(1'b1, 32'h0000_0008, 32'h1111_2222, 4'h3, 0, 1'b1, 32'h5555_AAAA);
        repeat (4) @(negedge PCLK);
        issue(1'b0, 32'h0000_1000, 32'h0, 4'hF, 25, 1'b0, 32'h7777_7777);
        repeat (20) @(negedge PCLK);
        issue(1'b0, 32'h0000_3000, 32'h0, 4'hF, 0, 1'b0, 32'h0);
        issue(1'b1, 32'h0000_0004, 32'hCAFE_F00D, 4'h5, 1, 1'b0, 32'h0);
        repeat (6) @(negedge PCLK);

        // Random traffic, back-to-back or with short gaps.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            int          w;
            a = $urandom;
            a[13:12] = 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(0, 5);
            issue(1'($urandom), a, $urandom, 4'($urandom), w, ($urandom_range(0, 3) == 0), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
        end

        for (int t = 0; t < 100 && sb.size() > 0; t++) @(negedge PCLK);
        chk("drain_pending", 64'(sb.size()), 64'(0));
        repeat (5) @(negedge PCLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
